// File: rtl/word_to_byte_mem_ctrl.sv
// Word-to-byte data memory initiator for the MEM stage: splits one 32-bit
// LDR/STR into four big-endian byte accesses over a req/ack byte port.
// Ports: clk, rst (async, active-high); mem_r_en, mem_w_en, address,
//   dataToWrite from EXE; result, freeze, done, err to the pipeline;
//   b_addr, b_wdata, b_we, b_re, b_rdata, b_ack on the byte port.
// Option: define BYTE_ACK_TIMEOUT_EN to abort a byte after TIMEOUT_CYCLES.
module word_to_byte_mem_ctrl #(
  parameter int unsigned BASE_ADDR      = 1024,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] dataToWrite,
  output logic [31:0] result,
  output logic        freeze,
  output logic        done,
  output logic        err,
  output logic [7:0]  b_addr,
  output logic [7:0]  b_wdata,
  output logic        b_we,
  output logic        b_re,
  input  logic [7:0]  b_rdata,
  input  logic        b_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [1:0]  k;
  logic [31:0] data_q;
  logic        is_store;
  logic        err_q;
  logic        req;
  logic        in_range;
  logic        last;
  logic        timeout;
  logic [31:0] diff;
  logic [31:0] off;

  assign req      = mem_r_en | mem_w_en;
  assign diff     = address - BASE_ADDR;
  // Unaligned addresses are aligned down to the word.
  assign off      = {diff[31:2], 2'b00};
  assign in_range = off < MEM_DEPTH;
  assign last     = (k == 2'd3);

  function automatic logic [7:0] byte_sel(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    logic [7:0] b;
    unique case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

`ifdef BYTE_ACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Restarts for every byte: any ack or leaving ACCESS clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != ACCESS || b_ack) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (state == ACCESS) && !b_ack &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt    = state;
    freeze = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (state)
      IDLE: begin
        freeze = req;
        if (req) begin
          nxt = in_range ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        freeze = 1'b1;
        if ((b_ack && last) || timeout) begin
          nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      b_addr   <= '0;
      b_wdata  <= '0;
      b_we     <= 1'b0;
      b_re     <= 1'b0;
      k        <= '0;
      data_q   <= '0;
      is_store <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            // Store wins when both enables are high.
            data_q   <= dataToWrite;
            is_store <= mem_w_en;
            k        <= '0;
            if (!mem_w_en) begin
              result <= '0;
            end
            if (!in_range) begin
              err_q <= 1'b1;
            end else begin
              b_addr  <= off[7:0];
              b_we    <= mem_w_en;
              b_re    <= !mem_w_en;
              b_wdata <= mem_w_en ? dataToWrite[31:24] : 8'h00;
            end
          end
        end
        ACCESS: begin
          if (b_ack) begin
            if (!is_store) begin
              unique case (k)
                2'd0:    result[31:24] <= b_rdata;
                2'd1:    result[23:16] <= b_rdata;
                2'd2:    result[15:8]  <= b_rdata;
                default: result[7:0]   <= b_rdata;
              endcase
            end
            if (last) begin
              b_we    <= 1'b0;
              b_re    <= 1'b0;
              b_wdata <= 8'h00;
              k       <= '0;
            end else begin
              k       <= k + 2'd1;
              b_addr  <= b_addr + 8'd1;
              b_wdata <= is_store ?
                         byte_sel(data_q, k + 2'd1) : 8'h00;
            end
          end else if (timeout) begin
            b_we    <= 1'b0;
            b_re    <= 1'b0;
            b_wdata <= 8'h00;
            k       <= '0;
            err_q   <= 1'b1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
